alu_result_fifo_acc: RTL and testbench

- Downstream stage of the 4-bit ALU. It captures each 5-bit ALU result together with the 2-bit operation select that produced it.
- Results are buffered in a small first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Every accepted result is also added into a saturating running accumulator, read by status/debug logic.

---
 rtl/alu_result_fifo_acc.sv | 176 +++++++++++++++++
 tb/tb_alu_result_fifo_acc.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo_acc.sv
// -----------------------------------------------------------------------------
// alu_result_fifo_acc
//
// Downstream stage of the 4-bit ALU. Each ALU result and the operation select
// that produced it are buffered in a first-word-fall-through FIFO with
// valid/ready handshakes on both sides. Every accepted result is also added
// into a saturating running accumulator that status/debug logic can read.
//
// Ports
//   clk        rising-edge clock, the only clock
//   rst_n      synchronous reset, active low
//   in_valid   result/tag present on in_data/in_sel
//   in_ready   FIFO can accept an entry this cycle
//   in_data    ALU result
//   in_sel     operation select that produced in_data
//   out_valid  head entry available
//   out_ready  consumer takes the head entry this cycle
//   out_data   head result (fall-through)
//   out_sel    head tag (fall-through)
//   count      current occupancy, 0..DEPTH
//   acc_clear  synchronous clear of accumulator and saturation flag
//   acc        saturating running sum of accepted results
//   acc_sat    sticky flag: the accumulator has saturated
// -----------------------------------------------------------------------------
module alu_result_fifo_acc #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 5,
  parameter int SEL_W  = 2,
  parameter int ACC_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [SEL_W-1:0]           in_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [SEL_W-1:0]           out_sel,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       acc_clear,
  output logic [ACC_W-1:0]           acc,
  output logic                       acc_sat
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = SEL_W + DATA_W;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic [ACC_W-1:0]   acc_q,    acc_d;
  logic               acc_sat_q, acc_sat_d;

  occ_e               occ;
  logic               push;
  logic               pop;

  // ---------------------------------------------------------------------------
  // Occupancy decode and handshakes: functions of count (and rst_n) only, so
  // neither side's ready/valid ever depends on the other side's request.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves it unassigned would infer a latch.
    occ = OCC_PARTIAL;
    if (count_q == '0) begin
      occ = OCC_EMPTY;
    end else if (count_q == FULL_CNT) begin
      occ = OCC_FULL;
    end
  end

  // Gated by rst_n so no push or pop can be accepted in a reset cycle, even
  // before count has been cleared by the first reset edge.
  assign in_ready  = rst_n && (occ != OCC_FULL);
  assign out_valid = rst_n && (occ != OCC_EMPTY);

  assign push = in_valid  && in_ready;
  assign pop  = out_valid && out_ready;

  // Fall-through head: the entry at the read pointer is always on the outputs.
  assign {out_sel, out_data} = mem_q[rd_ptr_q];

  assign count   = count_q;
  assign acc     = acc_q;
  assign acc_sat = acc_sat_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] acc_base;
  logic             sat_base;
  logic [ACC_W:0]   acc_sum;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    acc_d     = acc_q;
    acc_sat_d = acc_sat_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A clear in the same cycle as a push clears first, then adds.
    acc_base = acc_clear ? '0 : acc_q;
    sat_base = acc_clear ? 1'b0 : acc_sat_q;
    acc_sum  = {1'b0, acc_base} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};

    if (push) begin
      if (acc_sum[ACC_W]) begin
        acc_d     = ACC_MAX;
        acc_sat_d = 1'b1;
      end else begin
        acc_d     = acc_sum[ACC_W-1:0];
        acc_sat_d = sat_base;
      end
    end else if (acc_clear) begin
      acc_d     = '0;
      acc_sat_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      acc_q     <= '0;
      acc_sat_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      acc_sat_q <= acc_sat_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; its contents are only
  // observed when count says they are valid, and leaving out the reset lets it
  // map onto plain flops or RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_sel, in_data};
    end
  end

endmodule

// File: tb/tb_alu_result_fifo_acc.sv
// -----------------------------------------------------------------------------
// tb_alu_result_fifo_acc
//
// Directed and randomized stimulus for alu_result_fifo_acc, checked against a
// queue-based FIFO model and an integer saturating accumulator.
// -----------------------------------------------------------------------------
module tb_alu_result_fifo_acc;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 5;
  localparam int SEL_W  = 2;
  localparam int ACC_W  = 8;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [SEL_W-1:0]        out_sel;
  logic [$clog2(DEPTH):0]  count;
  logic                    acc_clear;
  logic [ACC_W-1:0]        acc;
  logic                    acc_sat;

  alu_result_fifo_acc #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .SEL_W (SEL_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sel  (out_sel),
    .count    (count),
    .acc_clear(acc_clear),
    .acc      (acc),
    .acc_sat  (acc_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO as a queue of {sel, data}, accumulator as an int.
  logic [SEL_W+DATA_W-1:0] model_q[$];
  int                      model_acc;
  bit                      model_sat;

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle of normal operation. Handshake/head outputs are checked
  // mid-cycle against the model, then registered state after the edge.
  task automatic step(input logic iv, input logic [DATA_W-1:0] d,
                      input logic [SEL_W-1:0] s, input logic ordy,
                      input logic clr);
    bit push_m;
    bit pop_m;
    int base;
    in_valid  = iv;
    in_data   = d;
    in_sel    = s;
    out_ready = ordy;
    acc_clear = clr;
    #1;
    check("in_ready",  32'(in_ready),  32'(model_q.size() < DEPTH));
    check("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
    if (model_q.size() > 0) begin
      check("out_data", 32'(out_data), 32'(model_q[0][DATA_W-1:0]));
      check("out_sel",  32'(out_sel),  32'(model_q[0][SEL_W+DATA_W-1:DATA_W]));
    end
    push_m = iv && (model_q.size() < DEPTH);
    pop_m  = ordy && (model_q.size() > 0);
    @(posedge clk);
    #1;
    if (pop_m)  void'(model_q.pop_front());
    if (push_m) model_q.push_back({s, d});
    if (push_m) begin
      base = clr ? 0 : model_acc;
      if (clr) model_sat = 1'b0;
      if (base + int'(d) > ACC_MAX) begin
        model_acc = ACC_MAX;
        model_sat = 1'b1;
      end else begin
        model_acc = base + int'(d);
      end
    end else if (clr) begin
      model_acc = 0;
      model_sat = 1'b0;
    end
    check("count",   32'(count),   32'(model_q.size()));
    check("acc",     32'(acc),     32'(model_acc));
    check("acc_sat", 32'(acc_sat), 32'(model_sat));
  endtask

  // Hold reset for n cycles with in_valid asserted, then release.
  task automatic do_reset(input int n);
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 5'h1F;
    in_sel    = 2'b11;
    out_ready = 1'b1;
    acc_clear = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst_in_ready",  32'(in_ready),  32'(0));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      @(posedge clk);
      #1;
    end
    model_q.delete();
    model_acc = 0;
    model_sat = 1'b0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("post_rst_in_ready",  32'(in_ready),  32'(1));
    check("post_rst_out_valid", 32'(out_valid), 32'(0));
    check("post_rst_count",     32'(count),     32'(0));
    check("post_rst_acc",       32'(acc),       32'(0));
    check("post_rst_acc_sat",   32'(acc_sat),   32'(0));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    model_acc = 0;
    model_sat = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    out_ready = 1'b0;
    acc_clear = 1'b0;

    // Reset then basic transfer.
    do_reset(2);
    step(1'b1, 5'h13, 2'b10, 1'b0, 1'b0);
    check("basic_acc", 32'(acc), 32'h13);
    step(1'b0, 5'h00, 2'b00, 1'b1, 1'b0);   // pop; head checked = 13/10
    check("basic_drained", 32'(out_valid), 32'(0));

    // Fill to full (clear with first push so the sum starts from zero).
    step(1'b1, 5'h01, 2'b00, 1'b0, 1'b1);
    step(1'b1, 5'h02, 2'b01, 1'b0, 1'b0);
    step(1'b1, 5'h03, 2'b10, 1'b0, 1'b0);
    step(1'b1, 5'h04, 2'b11, 1'b0, 1'b0);
    check("full_count", 32'(count), 32'd4);
    step(1'b1, 5'h05, 2'b00, 1'b0, 1'b0);   // refused
    check("full_refused_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 5'h00, 2'b00, 1'b1, 1'b0);
    check("fill_acc", 32'(acc), 32'h0A);

    // Simultaneous push/pop at count=2, then at count=4.
    step(1'b1, 5'h0A, 2'b01, 1'b0, 1'b0);
    step(1'b1, 5'h0B, 2'b10, 1'b0, 1'b0);
    step(1'b1, 5'h0C, 2'b11, 1'b1, 1'b0);
    check("pp_partial_count", 32'(count), 32'd2);
    step(1'b1, 5'h0D, 2'b00, 1'b0, 1'b0);
    step(1'b1, 5'h0E, 2'b01, 1'b0, 1'b0);
    step(1'b1, 5'h0F, 2'b10, 1'b1, 1'b0);   // full: pop only
    check("pp_full_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 5'h00, 2'b00, 1'b1, 1'b0);

    // Pointer wrap: values 0..9 streamed through.
    for (int i = 0; i < 10; i++) step(1'b1, 5'(i), 2'(i), 1'b1, 1'b0);
    step(1'b0, 5'h00, 2'b00, 1'b1, 1'b0);
    check("wrap_count", 32'(count), 32'd0);

    // Saturation then clear-with-push.
    step(1'b1, 5'h1F, 2'b11, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 5'h1F, 2'b11, 1'b1, 1'b0);
    check("sat_acc",  32'(acc),     32'hFF);
    check("sat_flag", 32'(acc_sat), 32'd1);
    step(1'b1, 5'h07, 2'b01, 1'b1, 1'b1);
    check("clr_push_acc",   32'(acc),     32'h07);
    check("clr_push_sat",   32'(acc_sat), 32'd0);
    check("clr_push_count", 32'(count),   32'd1);
    step(1'b0, 5'h00, 2'b00, 1'b1, 1'b0);

    // Reset mid-operation with count=3, acc=0x20.
    step(1'b1, 5'h10, 2'b00, 1'b0, 1'b1);
    step(1'b1, 5'h08, 2'b01, 1'b0, 1'b0);
    step(1'b1, 5'h08, 2'b10, 1'b0, 1'b0);
    check("pre_rst_acc", 32'(acc), 32'h20);
    do_reset(1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 5'($urandom), 2'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
